rv_iopmp_err_capture: RTL and testbench

Sequential error-record block that sits downstream of the IOPMP decision logic. It consumes the per-transaction violation report (valid, error type, entry index) together with the checked transaction's address, SID and access type. It latches the first violation into a software-visible error record and holds it until software clears it. It also counts and flags later violations that arrive while a record is held, and drives a level interrupt.

---
 rtl/rv_iopmp_err_capture.sv | 184 ++++++++++++++++++
 tb/tb_rv_iopmp_err_capture.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_iopmp_err_capture.sv
`default_nettype none

// ============================================================================
// Package    : rv_iopmp_pkg
// Description: Shared IOPMP types. access_t encodes the access type of the
//              transaction that was checked.
// Revision   : 1.0 - initial release
// ============================================================================
package rv_iopmp_pkg;
    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2,
        ACCESS_EXEC  = 2'd3
    } access_t;
endpackage : rv_iopmp_pkg

// ============================================================================
// Module     : rv_iopmp_err_capture
// Description: IOPMP error-record capture. Latches the first violation
//              reported by the decision logic into a software-visible record.
//              The record is held until software clears it. Later violations
//              that arrive while the record is held set a sticky flag and
//              bump a saturating counter. A level interrupt is driven while a
//              record is pending and interrupts are enabled.
// Ports      :
//   clk_i / rst_ni      clock, asynchronous active-low reset
//   chk_valid_i         decision result valid this cycle
//   err_transaction_i   violation flag (qualified by chk_valid_i)
//   err_type_i          violation type
//   err_entry_index_i   offending entry index
//   addr_i/sid_i        checked transaction address / source ID
//   access_type_i       checked transaction access type
//   intr_en_i           global interrupt enable
//   clear_i             W1C pulse clearing the pending record
//   err_*_o             latched record, sticky flag and drop counter
//   irq_o               level interrupt
// Revision   : 1.0 - initial release
// ============================================================================
module rv_iopmp_err_capture #(
    parameter int SID_WIDTH  = 8,
    parameter int ADDR_WIDTH = 64,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      chk_valid_i,
    input  logic                      err_transaction_i,
    input  logic [2:0]                err_type_i,
    input  logic [15:0]               err_entry_index_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [SID_WIDTH-1:0]      sid_i,
    input  rv_iopmp_pkg::access_t     access_type_i,
    input  logic                      intr_en_i,
    input  logic                      clear_i,
    output logic                      err_valid_o,
    output logic [2:0]                err_etype_o,
    output rv_iopmp_pkg::access_t     err_ttype_o,
    output logic [15:0]               err_eid_o,
    output logic [ADDR_WIDTH-1:0]     err_addr_o,
    output logic [SID_WIDTH-1:0]      err_sid_o,
    output logic                      err_svc_o,
    output logic [CNT_WIDTH-1:0]      err_drop_cnt_o,
    output logic                      irq_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_cap;
    logic                     w_load;
    logic                     w_svc_nxt;
    logic [CNT_WIDTH-1:0]     w_cnt_nxt;

    logic [2:0]               r_etype;
    rv_iopmp_pkg::access_t    r_ttype;
    logic [15:0]              r_eid;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [SID_WIDTH-1:0]     r_sid;
    logic                     r_svc;
    logic [CNT_WIDTH-1:0]     r_cnt;

    assign w_cap = chk_valid_i & err_transaction_i;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, record load strobe, sticky flag and counter update
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_svc_nxt   = r_svc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                // clear_i has nothing to clear here
                if (w_cap) begin
                    w_state_nxt = ST_HELD;
                    w_load      = 1'b1;
                    w_svc_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_HELD: begin
                if (clear_i && w_cap) begin
                    // Clear and a new violation collide: take the new one so
                    // it is never lost, and restart the overflow bookkeeping.
                    w_load    = 1'b1;
                    w_svc_nxt = 1'b0;
                    w_cnt_nxt = '0;
                end else if (clear_i) begin
                    w_state_nxt = ST_IDLE;
                    w_svc_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (w_cap) begin
                    w_svc_nxt = 1'b1;
                    if (r_cnt != C_CNT_MAX) begin
                        w_cnt_nxt = r_cnt + C_CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Record fields, sticky flag and drop counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_etype <= '0;
            r_ttype <= rv_iopmp_pkg::ACCESS_NONE;
            r_eid   <= '0;
            r_addr  <= '0;
            r_sid   <= '0;
            r_svc   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_load) begin
                r_etype <= err_type_i;
                r_ttype <= access_type_i;
                r_eid   <= err_entry_index_i;
                r_addr  <= addr_i;
                r_sid   <= sid_i;
            end
            r_svc <= w_svc_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign err_valid_o    = (r_state == ST_HELD);
    assign err_etype_o    = r_etype;
    assign err_ttype_o    = r_ttype;
    assign err_eid_o      = r_eid;
    assign err_addr_o     = r_addr;
    assign err_sid_o      = r_sid;
    assign err_svc_o      = r_svc;
    assign err_drop_cnt_o = r_cnt;
    // Pending state is registered; the enable only masks it, so toggling
    // intr_en_i never loses a pending record.
    assign irq_o          = err_valid_o & intr_en_i;

endmodule : rv_iopmp_err_capture

`default_nettype wire

// File: tb/tb_rv_iopmp_err_capture.sv
`default_nettype none

// ============================================================================
// Module     : tb_rv_iopmp_err_capture
// Description: Self-checking bench for rv_iopmp_err_capture. A table of
//              stimulus/expected records is applied cycle by cycle; expected
//              records are queued when driven and popped when the DUT output
//              is sampled. Hand-written sequences cover the interrupt mask,
//              counter saturation and asynchronous reset.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_rv_iopmp_err_capture;
    import rv_iopmp_pkg::*;

    localparam int SID_W  = 8;
    localparam int ADDR_W = 64;
    localparam int CNT_W  = 8;

    typedef struct {
        logic               cv;
        logic               et;
        logic [2:0]         ety;
        logic [15:0]        eid;
        logic [ADDR_W-1:0]  addr;
        logic [SID_W-1:0]   sid;
        access_t            acc;
        logic               ien;
        logic               clr;
        logic               x_valid;
        logic [2:0]         x_ety;
        logic [15:0]        x_eid;
        logic [ADDR_W-1:0]  x_addr;
        logic [SID_W-1:0]   x_sid;
        access_t            x_acc;
        logic               x_svc;
        logic [CNT_W-1:0]   x_cnt;
        logic               x_irq;
    } vec_t;

    logic               clk;
    logic               rst_n;
    logic               chk_valid;
    logic               err_tr;
    logic [2:0]         err_type;
    logic [15:0]        err_eid_in;
    logic [ADDR_W-1:0]  addr;
    logic [SID_W-1:0]   sid;
    access_t            acc;
    logic               intr_en;
    logic               clr;
    logic               o_valid;
    logic [2:0]         o_etype;
    access_t            o_ttype;
    logic [15:0]        o_eid;
    logic [ADDR_W-1:0]  o_addr;
    logic [SID_W-1:0]   o_sid;
    logic               o_svc;
    logic [CNT_W-1:0]   o_cnt;
    logic               o_irq;

    int n_run  = 0;
    int n_fail = 0;
    vec_t sb_q[$];
    vec_t tbl[15];

    rv_iopmp_err_capture #(
        .SID_WIDTH  (SID_W),
        .ADDR_WIDTH (ADDR_W),
        .CNT_WIDTH  (CNT_W)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .chk_valid_i       (chk_valid),
        .err_transaction_i (err_tr),
        .err_type_i        (err_type),
        .err_entry_index_i (err_eid_in),
        .addr_i            (addr),
        .sid_i             (sid),
        .access_type_i     (acc),
        .intr_en_i         (intr_en),
        .clear_i           (clr),
        .err_valid_o       (o_valid),
        .err_etype_o       (o_etype),
        .err_ttype_o       (o_ttype),
        .err_eid_o         (o_eid),
        .err_addr_o        (o_addr),
        .err_sid_o         (o_sid),
        .err_svc_o         (o_svc),
        .err_drop_cnt_o    (o_cnt),
        .irq_o             (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        input logic cv, input logic et, input logic [2:0] ety,
        input logic [15:0] eid, input logic [ADDR_W-1:0] a,
        input logic [SID_W-1:0] s, input access_t ac,
        input logic ien, input logic cl,
        input logic xv, input logic [2:0] xety, input logic [15:0] xeid,
        input logic [ADDR_W-1:0] xa, input logic [SID_W-1:0] xs,
        input access_t xac, input logic xsvc, input logic [CNT_W-1:0] xcnt,
        input logic xirq);
        vec_t v;
        v.cv = cv; v.et = et; v.ety = ety; v.eid = eid; v.addr = a;
        v.sid = s; v.acc = ac; v.ien = ien; v.clr = cl;
        v.x_valid = xv; v.x_ety = xety; v.x_eid = xeid; v.x_addr = xa;
        v.x_sid = xs; v.x_acc = xac; v.x_svc = xsvc; v.x_cnt = xcnt;
        v.x_irq = xirq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        chk_valid = 1'b0; err_tr = 1'b0; err_type = 3'd0; err_eid_in = 16'd0;
        addr = '0; sid = '0; acc = ACCESS_NONE; clr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, 64'(o_valid), 64'd0);
        chk({tag, ".svc"},   64'(o_svc),   64'd0);
        chk({tag, ".cnt"},   64'(o_cnt),   64'd0);
        chk({tag, ".irq"},   64'(o_irq),   64'd0);
        chk({tag, ".etype"}, 64'(o_etype), 64'd0);
        chk({tag, ".ttype"}, 64'(o_ttype), 64'd0);
        chk({tag, ".eid"},   64'(o_eid),   64'd0);
        chk({tag, ".addr"},  64'(o_addr),  64'd0);
        chk({tag, ".sid"},   64'(o_sid),   64'd0);
    endtask

    // Drive one vector at the falling edge, queue its expectation, then pop
    // and compare just after the following rising edge.
    task automatic run_vec(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        chk_valid = v.cv; err_tr = v.et; err_type = v.ety; err_eid_in = v.eid;
        addr = v.addr; sid = v.sid; acc = v.acc; intr_en = v.ien; clr = v.clr;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".valid"}, 64'(o_valid), 64'(e.x_valid));
        chk({tag, ".etype"}, 64'(o_etype), 64'(e.x_ety));
        chk({tag, ".eid"},   64'(o_eid),   64'(e.x_eid));
        chk({tag, ".addr"},  64'(o_addr),  64'(e.x_addr));
        chk({tag, ".sid"},   64'(o_sid),   64'(e.x_sid));
        chk({tag, ".ttype"}, 64'(o_ttype), 64'(e.x_acc));
        chk({tag, ".svc"},   64'(o_svc),   64'(e.x_svc));
        chk({tag, ".cnt"},   64'(o_cnt),   64'(e.x_cnt));
        chk({tag, ".irq"},   64'(o_irq),   64'(e.x_irq));
    endtask

    initial begin
        logic [ADDR_W-1:0] a0, a7, a14;
        vec_t v;
        a0  = 64'h0000_0000_8000_1000;
        a7  = 64'hDEAD_BEEF_0000_0040;
        a14 = 64'h0000_0000_0000_0010;

        //              cv   et  ety   eid      addr        sid    acc           ien  clr | valid ety   eid      addr sid   acc           svc  cnt   irq
        tbl[0]  = mk(1'b1,1'b1,3'd2,16'h0004,a0,          8'd1,  ACCESS_WRITE,1'b1,1'b0,  1'b1,3'd2,16'h0004,a0, 8'd1,  ACCESS_WRITE,1'b0,8'd0,1'b1);
        tbl[1]  = mk(1'b1,1'b1,3'd1,16'h0007,64'h2000,    8'd3,  ACCESS_READ, 1'b1,1'b0,  1'b1,3'd2,16'h0004,a0, 8'd1,  ACCESS_WRITE,1'b1,8'd1,1'b1);
        tbl[2]  = mk(1'b1,1'b1,3'd3,16'h0009,64'h3000,    8'd4,  ACCESS_EXEC, 1'b1,1'b0,  1'b1,3'd2,16'h0004,a0, 8'd1,  ACCESS_WRITE,1'b1,8'd2,1'b1);
        tbl[3]  = mk(1'b1,1'b1,3'd7,16'h00AA,64'h4000,    8'd5,  ACCESS_READ, 1'b1,1'b0,  1'b1,3'd2,16'h0004,a0, 8'd1,  ACCESS_WRITE,1'b1,8'd3,1'b1);
        tbl[4]  = mk(1'b0,1'b0,3'd0,16'h0000,64'h0,       8'd0,  ACCESS_NONE, 1'b1,1'b1,  1'b0,3'd2,16'h0004,a0, 8'd1,  ACCESS_WRITE,1'b0,8'd0,1'b0);
        // violation flag without chk_valid: ignored
        tbl[5]  = mk(1'b0,1'b1,3'd6,16'h0011,64'h5000,    8'd9,  ACCESS_EXEC, 1'b1,1'b0,  1'b0,3'd2,16'h0004,a0, 8'd1,  ACCESS_WRITE,1'b0,8'd0,1'b0);
        // clear in IDLE: no effect
        tbl[6]  = mk(1'b0,1'b0,3'd0,16'h0000,64'h0,       8'd0,  ACCESS_NONE, 1'b1,1'b1,  1'b0,3'd2,16'h0004,a0, 8'd1,  ACCESS_WRITE,1'b0,8'd0,1'b0);
        // capture with interrupts masked
        tbl[7]  = mk(1'b1,1'b1,3'd6,16'h0010,a7,          8'hFF, ACCESS_NONE, 1'b0,1'b0,  1'b1,3'd6,16'h0010,a7, 8'hFF, ACCESS_NONE, 1'b0,8'd0,1'b0);
        tbl[8]  = mk(1'b0,1'b0,3'd0,16'h0000,64'h0,       8'd0,  ACCESS_NONE, 1'b0,1'b0,  1'b1,3'd6,16'h0010,a7, 8'hFF, ACCESS_NONE, 1'b0,8'd0,1'b0);
        tbl[9]  = mk(1'b1,1'b1,3'd1,16'h0101,64'h6000,    8'd10, ACCESS_READ, 1'b1,1'b0,  1'b1,3'd6,16'h0010,a7, 8'hFF, ACCESS_NONE, 1'b1,8'd1,1'b1);
        tbl[10] = mk(1'b1,1'b1,3'd2,16'h0102,64'h6100,    8'd11, ACCESS_WRITE,1'b1,1'b0,  1'b1,3'd6,16'h0010,a7, 8'hFF, ACCESS_NONE, 1'b1,8'd2,1'b1);
        tbl[11] = mk(1'b1,1'b1,3'd3,16'h0103,64'h6200,    8'd12, ACCESS_EXEC, 1'b1,1'b0,  1'b1,3'd6,16'h0010,a7, 8'hFF, ACCESS_NONE, 1'b1,8'd3,1'b1);
        tbl[12] = mk(1'b1,1'b1,3'd5,16'h0104,64'h6300,    8'd13, ACCESS_READ, 1'b1,1'b0,  1'b1,3'd6,16'h0010,a7, 8'hFF, ACCESS_NONE, 1'b1,8'd4,1'b1);
        tbl[13] = mk(1'b1,1'b1,3'd7,16'h0105,64'h6400,    8'd14, ACCESS_WRITE,1'b1,1'b0,  1'b1,3'd6,16'h0010,a7, 8'hFF, ACCESS_NONE, 1'b1,8'd5,1'b1);
        // clear and capture in the same cycle: new record, counters reset
        tbl[14] = mk(1'b1,1'b1,3'd5,16'h0020,a14,         8'd2,  ACCESS_READ, 1'b1,1'b1,  1'b1,3'd5,16'h0020,a14,8'd2,  ACCESS_READ, 1'b0,8'd0,1'b1);

        // Reset state
        rst_n = 1'b0;
        intr_en = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
            if (i == 8) begin
                // Unmask/mask the interrupt between edges: irq follows at once.
                intr_en = 1'b1;
                #1;
                chk("ien_up.irq",   64'(o_irq),   64'd1);
                chk("ien_up.valid", 64'(o_valid), 64'd1);
                intr_en = 1'b0;
                #1;
                chk("ien_down.irq",   64'(o_irq),   64'd0);
                chk("ien_down.valid", 64'(o_valid), 64'd1);
            end
        end

        // Saturation: 300 captures while held starting from cnt=0.
        for (int k = 1; k <= 300; k++) begin
            v = mk(1'b1, 1'b1, 3'd3, 16'(k), 64'(k), 8'(k), ACCESS_EXEC, 1'b1, 1'b0,
                   1'b1, 3'd5, 16'h0020, a14, 8'd2, ACCESS_READ, 1'b1,
                   (k > 255) ? 8'd255 : 8'(k), 1'b1);
            run_vec($sformatf("sat%0d", k), v);
        end

        // Asynchronous reset between clock edges while held with svc=1.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        drive_idle();
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // First capture after reset release is recorded normally.
        v = mk(1'b1, 1'b1, 3'd1, 16'h0033, 64'h0000_0000_0000_7000, 8'd7, ACCESS_READ, 1'b1, 1'b0,
               1'b1, 3'd1, 16'h0033, 64'h0000_0000_0000_7000, 8'd7, ACCESS_READ, 1'b0, 8'd0, 1'b1);
        run_vec("post_rst_cap", v);
        v = mk(1'b0, 1'b0, 3'd0, 16'h0000, 64'h0, 8'd0, ACCESS_NONE, 1'b1, 1'b1,
               1'b0, 3'd1, 16'h0033, 64'h0000_0000_0000_7000, 8'd7, ACCESS_READ, 1'b0, 8'd0, 1'b0);
        run_vec("post_rst_clr", v);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_rv_iopmp_err_capture

`default_nettype wire
